// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and constants for the BRAM port arbiter
package bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  localparam int ARB_ADDR_W = 11;
  localparam int ARB_DATA_W = 16;
  localparam int PERF_CNT_W = 16;

  // Requesters eligible for a grant in a given lock state.
  function automatic logic [1:0] lock_mask(input arb_state_e s);
    case (s)
      ST_LOCK0: lock_mask = 2'b01;
      ST_LOCK1: lock_mask = 2'b10;
      default:  lock_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/bram_arb_rr2.sv
// rtl/bram_arb_rr2.sv - 2-way round-robin grant with last-granted pointer
module bram_arb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic [1:0] mask,
  input  logic       force_en,
  input  logic       force_last,
  output logic [1:0] grant
);

  logic       last_q;
  logic [1:0] cand;

  always_comb begin
    cand  = valid & mask;
    grant = cand;
    if (cand == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end

  // last_q resets to 1 so that req0 wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_q <= 1'b1;
    else if (force_en)   last_q <= force_last;
    else if (|grant)     last_q <= grant[1];
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester arbiter with lock/timeout in front of a single-port BRAM
// Optional grant counters enabled by BRAM_ARB_PERF_EN.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int LOCK_MAX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              lock_timeout
`ifdef BRAM_ARB_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [PERF_CNT_W-1:0] grant_cnt0,
  output logic [PERF_CNT_W-1:0] grant_cnt1
`endif
);

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [1:0]       grant;
  logic [1:0]       rsp_valid_q;
  logic             sel_we, sel_lock, in_lock, release_x, timeout;

  bram_arb_rr2 u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      ({req1_valid, req0_valid}),
    .mask       (lock_mask(state_q)),
    .force_en   (timeout),
    .force_last (state_q == ST_LOCK1),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (grant[0]) begin
      sel_we    = req0_we;
      sel_lock  = req0_lock;
      bram_addr = req0_addr;
      bram_din  = req0_wdata;
    end else if (grant[1]) begin
      sel_we    = req1_we;
      sel_lock  = req1_lock;
      bram_addr = req1_addr;
      bram_din  = req1_wdata;
    end
  end

  assign bram_we = sel_we;

  // While locked only the owner can be granted, so any grant is the owner's.
  always_comb begin
    in_lock   = (state_q != ST_IDLE);
    release_x = in_lock && (|grant) && !sel_lock;
    timeout   = in_lock && (lock_cnt_q == CNT_MAX) && !release_x;
    state_d   = state_q;
    case (state_q)
      ST_IDLE:  if ((|grant) && sel_lock) state_d = grant[1] ? ST_LOCK1 : ST_LOCK0;
      default:  if (release_x || timeout) state_d = ST_IDLE;
    endcase
  end

  assign lock_timeout = timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_cnt_q  <= '0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= grant & {2{~sel_we}};
      if (state_q == ST_IDLE)       lock_cnt_q <= '0;
      else if (lock_cnt_q != CNT_MAX) lock_cnt_q <= lock_cnt_q + 1'b1;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp_valid_q[0] ? bram_dout : '0;
  assign rsp1_rdata = rsp_valid_q[1] ? bram_dout : '0;

`ifdef BRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (perf_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (grant[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed and randomized bench for bram_port_arbiter
module tb_bram_port_arbiter;

  localparam int LOCK_MAX = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v [2];
  logic        we[2];
  logic        lk[2];
  logic [10:0] ad[2];
  logic [15:0] wd[2];
  logic        perf_clr = 1'b0;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, bram_we, lock_timeout;
  logic [15:0] rsp0_rdata, rsp1_rdata, bram_din, bram_dout;
  logic [10:0] bram_addr;
`ifdef BRAM_ARB_PERF_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  bram_port_arbiter #(.ADDR_W(11), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_we(we[0]), .req0_lock(lk[0]),
    .req0_addr(ad[0]), .req0_wdata(wd[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_we(we[1]), .req1_lock(lk[1]),
    .req1_addr(ad[1]), .req1_wdata(wd[1]),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_dout(bram_dout),
    .lock_timeout(lock_timeout)
`ifdef BRAM_ARB_PERF_EN
    , .perf_clr(perf_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Behavioural single-port BRAM with registered output.
  logic [15:0] bmem [2048];
  always @(posedge clk) begin
    if (bram_we) bmem[bram_addr] <= bram_din;
    bram_dout <= bmem[bram_addr];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: owner of lock (-1 none), last granted, cycles held, memory image.
  int          own, last, held;
  logic [15:0] ref_mem [2048];
  logic        exp_rv [2];
  logic [15:0] exp_rd [2];
  logic        obs_r0, obs_r1, obs_to;
  int          rsp_cnt [2];

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 37) ^ 16'h5A5A;
  endfunction

  task automatic model_reset();
    own = -1; last = 1; held = 0;
    exp_rv[0] = 0; exp_rv[1] = 0;
  endtask

  task automatic step();
    int g;
    bit c0, c1, rel, to;
    #1;
    c0 = v[0] && (own != 1);
    c1 = v[1] && (own != 0);
    g = -1;
    if (c0 && c1) g = (last == 0) ? 1 : 0;
    else if (c0) g = 0;
    else if (c1) g = 1;
    rel = (own >= 0) && (g == own) && !lk[own];
    to  = (own >= 0) && (held == LOCK_MAX - 1) && !rel;
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_to = lock_timeout;
    chk("ready0", 32'(req0_ready), 32'(g == 0));
    chk("ready1", 32'(req1_ready), 32'(g == 1));
    chk("lock_timeout", 32'(lock_timeout), 32'(to));
    chk("bram_we", 32'(bram_we), 32'((g >= 0) ? we[g] : 1'b0));
    chk("bram_addr", 32'(bram_addr), 32'((g >= 0) ? ad[g] : 11'd0));
    chk("bram_din", 32'(bram_din), 32'((g >= 0) ? wd[g] : 16'd0));
    @(posedge clk);
    exp_rv[0] = 0; exp_rv[1] = 0;
    if (g >= 0) begin
      if (we[g]) ref_mem[ad[g]] = wd[g];
      else begin exp_rv[g] = 1; exp_rd[g] = ref_mem[ad[g]]; end
      last = g;
    end
    if (own < 0) begin
      if (g >= 0 && lk[g]) begin own = g; held = 0; end
    end else if (rel) own = -1;
    else if (to) begin last = own; own = -1; end
    else held++;
    #1;
    chk("rsp0_valid", 32'(rsp0_valid), 32'(exp_rv[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(exp_rv[1]));
    chk("rsp0_rdata", 32'(rsp0_rdata), 32'(exp_rv[0] ? exp_rd[0] : 16'd0));
    chk("rsp1_rdata", 32'(rsp1_rdata), 32'(exp_rv[1] ? exp_rd[1] : 16'd0));
    if (rsp0_valid) rsp_cnt[0]++;
    if (rsp1_valid) rsp_cnt[1]++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; we[i] = 0; lk[i] = 0; ad[i] = '0; wd[i] = '0;
    end
  endtask

  initial begin
    int to_at;
    for (int i = 0; i < 2048; i++) begin
      bmem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_lock_timeout", 32'(lock_timeout), 32'd0);
    chk("rst_bram_we", 32'(bram_we), 32'd0);
    rst_n = 1'b1;

    // 1: write then read-back across requesters
    v[0] = 1; we[0] = 1; ad[0] = 11'h005; wd[0] = 16'hBEEF;
    step();
    idle_inputs();
    v[1] = 1; ad[1] = 11'h005;
    step();
    chk("t1_rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("t1_rsp1_rdata", 32'(rsp1_rdata), 32'hBEEF);

    // 2: both reading every cycle alternates
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    v[0] = 1; ad[0] = 11'h003; v[1] = 1; ad[1] = 11'h007;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_alt", 32'(obs_r0), 32'((i % 2) == 0));
    end
    chk("t2_rsp0_cnt", 32'(rsp_cnt[0]), 32'd4);
    chk("t2_rsp1_cnt", 32'(rsp_cnt[1]), 32'd4);

    // 3: locked read-modify-write blocks the other requester
    lk[0] = 1; ad[0] = 11'h010; ad[1] = 11'h011;
    step();
    chk("t3_lock_grant", 32'(obs_r0), 32'd1);
    v[0] = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_blocked", 32'(obs_r1), 32'd0);
    end
    v[0] = 1; we[0] = 1; lk[0] = 0; wd[0] = 16'h1234;
    step();
    chk("t3_wr_grant", 32'(obs_r0), 32'd1);
    chk("t3_wr_block1", 32'(obs_r1), 32'd0);
    v[0] = 0;
    step();
    chk("t3_req1_after", 32'(obs_r1), 32'd1);

    // 4: idle lock owner is forced out
    idle_inputs();
    v[1] = 1; lk[1] = 1; ad[1] = 11'h020;
    step();
    chk("t4_lock_grant", 32'(obs_r1), 32'd1);
    idle_inputs();
    v[0] = 1; ad[0] = 11'h021;
    to_at = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (obs_to) begin to_at = n; break; end
    end
    chk("t4_timeout_cycle", 32'(to_at), 32'd64);
    step();
    chk("t4_req0_after", 32'(obs_r0), 32'd1);

    // 5: reset during lock with a read response pending
    idle_inputs();
    v[0] = 1; lk[0] = 1; ad[0] = 11'h030;
    #1;
    chk("t5_lock_grant", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rsp0_dropped", 32'(rsp0_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    v[1] = 1; ad[1] = 11'h031; lk[0] = 0;
    step();
    chk("t5_idle_arb", 32'(obs_r0), 32'd1);
    step();
    chk("t5_idle_arb_rr", 32'(obs_r1), 32'd1);

`ifdef BRAM_ARB_PERF_EN
    // 6: grant counters and clear priority
    idle_inputs();
    perf_clr = 1;
    step();
    perf_clr = 0;
    v[0] = 1; we[0] = 1; ad[0] = 11'h040; wd[0] = 16'h00AA;
    for (int i = 0; i < 10; i++) step();
    chk("t6_cnt10", 32'(grant_cnt0), 32'd10);
    perf_clr = 1;
    step();
    perf_clr = 0;
    chk("t6_cnt_clr", 32'(grant_cnt0), 32'd0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        v[r]  = 1'($urandom_range(0, 3) != 0);
        we[r] = 1'($urandom_range(0, 1));
        lk[r] = 1'($urandom_range(0, 5) == 0);
        ad[r] = 11'($urandom_range(0, 15));
        wd[r] = 16'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
